video_timing_gen: RTL



---
 rtl/video_pkg.sv | 27 ++
 rtl/sync_delay_line.sv | 28 ++
 rtl/video_timing_gen.sv | 79 +++++++
 3 files changed

// File: rtl/video_pkg.sv
// video_pkg: video mode descriptor type and standard CEA/VESA timing sets.
package video_pkg;
  typedef struct packed {
    logic [15:0] h_active;
    logic [15:0] h_fp;
    logic [15:0] h_sync;
    logic [15:0] h_bp;
    logic [15:0] v_active;
    logic [15:0] v_fp;
    logic [15:0] v_sync;
    logic [15:0] v_bp;
    logic        h_pol;
    logic        v_pol;
  } vtg_mode_t;
  localparam vtg_mode_t MODE_640x480_60 = '{
    16'd640, 16'd16, 16'd96, 16'd48, 16'd480, 16'd10, 16'd2, 16'd33, 1'b0, 1'b0};
  localparam vtg_mode_t MODE_1280x720_60 = '{
    16'd1280, 16'd110, 16'd40, 16'd220, 16'd720, 16'd5, 16'd5, 16'd20, 1'b1, 1'b1};
  localparam vtg_mode_t MODE_1920x1080_60 = '{
    16'd1920, 16'd88, 16'd44, 16'd148, 16'd1080, 16'd4, 16'd5, 16'd36, 1'b1, 1'b1};
  function automatic int mode_h_total(input vtg_mode_t m);
    return int'(m.h_active) + int'(m.h_fp) + int'(m.h_sync) + int'(m.h_bp);
  endfunction
  function automatic int mode_v_total(input vtg_mode_t m);
    return int'(m.v_active) + int'(m.v_fp) + int'(m.v_sync) + int'(m.v_bp);
  endfunction
endpackage

// File: rtl/sync_delay_line.sv
// sync_delay_line: en-gated shift register of DEPTH stages; wire when DEPTH is 0.
module sync_delay_line #(
  parameter int           W       = 1,
  parameter int           DEPTH   = 0,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  if (DEPTH == 0) begin : g_pass
    logic unused_ctl;
    assign unused_ctl = &{1'b0, clk, reset_n, en};
    assign q = d;
  end else begin : g_pipe
    logic [W-1:0] sr [DEPTH];
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        for (int i = 0; i < DEPTH; i++) sr[i] <= RST_VAL;
      end else if (en) begin
        sr[0] <= d;
        for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
    assign q = sr[DEPTH-1];
  end
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster counters, sync, vde and line/frame strobes for a parametrised mode.
// Define VTG_FRAME_CNT_EN to enable the frame_cnt counter; otherwise frame_cnt is tied 0.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = int'(MODE_640x480_60.h_active),
  parameter int H_FP     = int'(MODE_640x480_60.h_fp),
  parameter int H_SYNC   = int'(MODE_640x480_60.h_sync),
  parameter int H_BP     = int'(MODE_640x480_60.h_bp),
  parameter int V_ACTIVE = int'(MODE_640x480_60.v_active),
  parameter int V_FP     = int'(MODE_640x480_60.v_fp),
  parameter int V_SYNC   = int'(MODE_640x480_60.v_sync),
  parameter int V_BP     = int'(MODE_640x480_60.v_bp),
  parameter int H_POL    = int'(MODE_640x480_60.h_pol),
  parameter int V_POL    = int'(MODE_640x480_60.v_pol),
  parameter int CNT_W    = 10,
  parameter int SYNC_DLY = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             hsync,
  output logic             vsync,
  output logic             vde,
  output logic             line_start,
  output logic             frame_start,
  output logic [15:0]      frame_cnt
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG = H_ACTIVE + H_FP;
  localparam int VS_BEG = V_ACTIVE + V_FP;
  localparam logic H_IDLE = (H_POL == 0);
  localparam logic V_IDLE = (V_POL == 0);
  localparam logic [4:0] IDLE = {3'b000, V_IDLE, H_IDLE};
  if (2**CNT_W < H_TOTAL || 2**CNT_W < V_TOTAL) begin : g_bad_cnt_w
    $error("video_timing_gen: CNT_W too small for H_TOTAL/V_TOTAL");
  end
  if (H_SYNC == 0 || V_SYNC == 0) begin : g_bad_sync
    $error("video_timing_gen: sync width must be non-zero");
  end
  if (SYNC_DLY < 0 || SYNC_DLY > 15) begin : g_bad_dly
    $error("video_timing_gen: SYNC_DLY must be 0..15");
  end
  logic       x_end, y_end, hs_act, vs_act;
  logic [4:0] st0_d, st0_q, st_out;
  assign x_end  = 32'(x) == H_TOTAL - 1;
  assign y_end  = 32'(y) == V_TOTAL - 1;
  assign hs_act = 32'(x) >= HS_BEG && 32'(x) < HS_BEG + H_SYNC;
  assign vs_act = 32'(y) >= VS_BEG && 32'(y) < VS_BEG + V_SYNC;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      x <= x_end ? '0 : x + 1'b1;
      if (x_end) y <= y_end ? '0 : y + 1'b1;
    end
  always_comb st0_d = {x == '0 && y == '0, x == '0,
                       32'(x) < H_ACTIVE && 32'(y) < V_ACTIVE,
                       vs_act ^ V_IDLE, hs_act ^ H_IDLE};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) st0_q <= IDLE;
    else if (en) st0_q <= st0_d;
  sync_delay_line #(.W(5), .DEPTH(SYNC_DLY), .RST_VAL(IDLE)) u_dly (
    .clk(clk), .reset_n(reset_n), .en(en), .d(st0_q), .q(st_out));
  assign {frame_start, line_start, vde, vsync, hsync} = st_out;
`ifdef VTG_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) frame_cnt_q <= '0;
    else if (en && frame_start) frame_cnt_q <= frame_cnt_q + 16'd1;
  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = '0;
`endif
endmodule
